// File: rtl/shift_register.sv
// Fixed four-stage delay line: data_in reappears on data_out four clk edges later.
// Latency: 4 cycles from the sampling edge to data_out; one new value accepted per cycle.
// Backpressure: none; no enable or stall, every stage advances on every clk edge.

// Single pipeline stage: a WIDTH-bit flop with synchronous active-low clear.
module shift_register_dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Capture d on each rising edge, or clear when reset_n is sampled low.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// Top level: four chained stages. The stage outputs are top-level signals so that
// waveform viewers and hierarchical probes can follow a value down the line.
module shift_register #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out
);

  logic [WIDTH-1:0] temp1_out;
  logic [WIDTH-1:0] temp2_out;
  logic [WIDTH-1:0] temp3_out;

  // Stage 1 samples the input pin directly.
  shift_register_dff #(.WIDTH(WIDTH)) u_stage1 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (data_in),
    .q       (temp1_out)
  );

  shift_register_dff #(.WIDTH(WIDTH)) u_stage2 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (temp1_out),
    .q       (temp2_out)
  );

  shift_register_dff #(.WIDTH(WIDTH)) u_stage3 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (temp2_out),
    .q       (temp3_out)
  );

  // Stage 4 drives the output port straight from its flop, so there is no
  // combinational path from any input to data_out.
  shift_register_dff #(.WIDTH(WIDTH)) u_stage4 (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (temp3_out),
    .q       (data_out)
  );

endmodule

// File: tb/tb_shift_register.sv
// Bench for shift_register: directed scenarios followed by random traffic with occasional resets.
// A delay-line model pushes the expected stage contents per edge; a monitor pops and compares.
// Stage values are also re-checked at the falling edge to confirm nothing moves between edges.
module tb_shift_register;

  localparam int W = 8;

  logic         clk;
  logic         reset_n;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;

  typedef struct {
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    logic [W-1:0] s3;
    logic [W-1:0] s4;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         cur;
  bit           have_cur = 0;
  logic [W-1:0] hist[$];
  bit           inited = 0;
  int           checks = 0;
  int           failures = 0;

  shift_register #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: a delay line of the last four accepted samples, newest first.
  // A reset edge replaces the whole history with zeros.
  always @(posedge clk) begin
    exp_t e;
    if (reset_n === 1'b0) begin
      hist = '{8'h00, 8'h00, 8'h00, 8'h00};
      inited = 1;
    end else if (inited) begin
      hist.push_front(data_in);
      void'(hist.pop_back());
    end
    if (inited) begin
      e.s1 = hist[0];
      e.s2 = hist[1];
      e.s3 = hist[2];
      e.s4 = hist[3];
      exp_q.push_back(e);
    end
  end

  // Monitor: compare just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      have_cur = 1;
      chk("temp1_out", dut.temp1_out, cur.s1);
      chk("temp2_out", dut.temp2_out, cur.s2);
      chk("temp3_out", dut.temp3_out, cur.s3);
      chk("data_out",  data_out,      cur.s4);
    end
  end

  // Stability: stages must still hold the same values at the falling edge.
  always @(negedge clk) begin
    if (have_cur) begin
      chk("temp1_out_hold", dut.temp1_out, cur.s1);
      chk("data_out_hold",  data_out,      cur.s4);
    end
  end

  task automatic drive(input logic r, input logic [W-1:0] d);
    @(negedge clk);
    reset_n = r;
    data_in = d;
  endtask

  int pulse_hits;

  initial begin
    reset_n = 1'b0;
    data_in = '0;

    // Reset held for two edges.
    drive(1'b0, 8'h00);
    drive(1'b0, 8'h00);

    // Bit shift pattern 1,0,1,1,0 then three zeros.
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h00);
    for (int i = 0; i < 3; i++) drive(1'b1, 8'h00);

    // Single-cycle pulse after reset; count cycles where data_out is 1.
    drive(1'b0, 8'h00);
    drive(1'b1, 8'h01);
    pulse_hits = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h00);
      if (data_out == 8'h01) pulse_hits++;
    end
    chk("pulse_cycles", pulse_hits[W-1:0], 8'd1);

    // Fill with ones, then reset in flight while data_in stays 1.
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h01);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h01);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h00);

    // Reset glitch between edges must be ignored.
    @(posedge clk);
    #2 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h00);

    // Wide values.
    drive(1'b1, 8'hA5);
    drive(1'b1, 8'h3C);
    drive(1'b1, 8'hFF);
    drive(1'b1, 8'h00);
    for (int i = 0; i < 5; i++) drive(1'b1, 8'h00);

    // Random traffic with occasional reset.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 15) != 0), W'($urandom));
    end
    drive(1'b1, 8'h00);
    drive(1'b1, 8'h00);

    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain: %0d expected entries never compared", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
